// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: sample format and signed max helper.
package cnn_pkg;

    localparam int unsigned DATA_WIDTH = 24;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream in / pooled stream out bundle for maxpool2x2_stream.
interface maxpool2x2_stream_if #(
    parameter int unsigned DATA_WIDTH = cnn_pkg::DATA_WIDTH
);
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic                         valid_out;
    logic                         last_out;

    // master drives the feature-map stream and observes the pooled output
    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out,
        input  last_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out,
        output last_out
    );
endinterface

// File: rtl/pool_linebuf.sv
// Half-width line buffer: synchronous write, asynchronous read, no reset.
module pool_linebuf #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 5,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata_c
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pool over a raster feature map.
// Optional build macro MAXPOOL_FUSED_RELU_EN clamps negative inputs to 0 before pooling.
module maxpool2x2_stream #(
    parameter int unsigned DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int unsigned IMG_W      = 10,
    parameter int unsigned IMG_H      = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    maxpool2x2_stream_if.slave   bus
);

    localparam int unsigned HALF_W = IMG_W / 2;
    localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    generate
        if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W == 0 || IMG_H == 0) begin : g_bad_geometry
            $error("maxpool2x2_stream: IMG_W and IMG_H must be even and non-zero");
        end
    endgenerate

    function automatic logic signed [DATA_WIDTH-1:0] max_s(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]                r_col;
    logic [RW-1:0]                r_row;
    logic signed [DATA_WIDTH-1:0] r_hold;
    logic signed [DATA_WIDTH-1:0] r_data_out;
    logic                         r_valid_out;
    logic                         r_last_out;

    logic signed [DATA_WIDTH-1:0] w_sample;
    logic signed [DATA_WIDTH-1:0] w_hmax;
    logic signed [DATA_WIDTH-1:0] w_pool;
    logic [DATA_WIDTH-1:0]        w_lb_rdata;
    logic [AW-1:0]                w_lb_addr;
    logic                         w_lb_we;
    logic                         w_col_last;
    logic                         w_row_last;

`ifdef MAXPOOL_FUSED_RELU_EN
    assign w_sample = bus.data_in[DATA_WIDTH-1] ? '0 : bus.data_in;
`else
    assign w_sample = bus.data_in;
`endif

    assign w_hmax     = max_s(r_hold, w_sample);
    assign w_pool     = max_s($signed(w_lb_rdata), w_hmax);
    assign w_lb_addr  = AW'(r_col >> 1);
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    // even rows park the horizontal max for the odd row below; reset blocks stray writes
    assign w_lb_we    = bus.valid_in && !rst && r_col[0] && !r_row[0];

    pool_linebuf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (HALF_W)
    ) u_linebuf (
        .clk       (clk),
        .i_we      (w_lb_we),
        .i_waddr   (w_lb_addr),
        .i_wdata   (w_hmax),
        .i_raddr   (w_lb_addr),
        .o_rdata_c (w_lb_rdata)
    );

    // raster counters, horizontal hold and registered pooled output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_hold      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
            if (bus.valid_in) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end

                if (!r_col[0]) begin
                    r_hold <= w_sample;
                end else if (r_row[0]) begin
                    r_data_out  <= w_pool;
                    r_valid_out <= 1'b1;
                    r_last_out  <= w_row_last && w_col_last;
                end
            end
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.last_out  = r_last_out;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream on a 10x10, 24-bit configuration.
module tb_maxpool2x2_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;

    maxpool2x2_stream_if #(.DATA_WIDTH(24)) bus ();

    maxpool2x2_stream #(
        .DATA_WIDTH (24),
        .IMG_W      (10),
        .IMG_H      (10)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_err  = 0;
    int n_out  = 0;
    int n_last = 0;

    logic               pend_v;
    logic signed [23:0] pend_d;
    logic               pend_l;
    logic signed [23:0] held_d;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // outputs seen now belong to the beat driven one call earlier
    task automatic check_prev();
        check_val("valid_out", 32'(bus.valid_out), 32'(pend_v));
        if (pend_v) begin
            check_val("data_out", bus.data_out, pend_d);
            check_val("last_out", 32'(bus.last_out), 32'(pend_l));
            n_out++;
            if (pend_l) n_last++;
            held_d = pend_d;
        end else begin
            check_val("last_idle", 32'(bus.last_out), 32'd0);
            check_val("data_hold", bus.data_out, held_d);
        end
    endtask

    task automatic send(input logic v, input logic signed [23:0] d,
                        input logic fire, input logic signed [23:0] ed, input logic el);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.valid_in = v;
        bus.data_in  = d;
        @(negedge clk);
        check_prev();
        pend_v = v & fire;
        pend_d = ed;
        pend_l = el;
    endtask

    task automatic idle();
        send(1'b0, 24'sd0, 1'b0, 24'sd0, 1'b0);
    endtask

    // reset pulse with valid_in high to confirm reset wins
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 24'sd777;
        @(negedge clk);
        check_prev();
        pend_v = 1'b0;
        pend_l = 1'b0;
        held_d = 24'sd0;
    endtask

    function automatic logic signed [23:0] pix(input int kind, input int r, input int c);
        logic [1:0] q;
        q = {1'(r % 2), 1'(c % 2)};
        case (kind)
            0: return 24'(r * 10 + c);
            1: case (q)
                   2'b00:   return -24'sd5;
                   2'b01:   return -24'sd3;
                   2'b10:   return -24'sd8;
                   default: return -24'sd100;
               endcase
            2: case (q)
                   2'b00:   return 24'h7FFFFF;
                   2'b01:   return 24'h800000;
                   2'b10:   return 24'h000000;
                   default: return 24'h000001;
               endcase
            default: return 24'h800000;
        endcase
    endfunction

    function automatic logic signed [23:0] expect_out(input int kind, input int r, input int c);
        case (kind)
            0:       return 24'(r * 10 + c);
`ifdef MAXPOOL_FUSED_RELU_EN
            1:       return 24'sd0;
            2:       return 24'h7FFFFF;
            default: return 24'sd0;
`else
            1:       return -24'sd3;
            2:       return 24'h7FFFFF;
            default: return 24'h800000;
`endif
        endcase
    endfunction

    task automatic frame(input int kind, input int gap_pct, input int npix);
        for (int p = 0; p < npix; p++) begin
            int r;
            int c;
            r = p / 10;
            c = p % 10;
            while (gap_pct > 0 && $urandom_range(0, 99) < 32'(gap_pct)) idle();
            send(1'b1, pix(kind, r, c), ((r % 2) == 1) && ((c % 2) == 1),
                 expect_out(kind, r, c), (r == 9) && (c == 9));
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        pend_v = 1'b0;
        pend_d = '0;
        pend_l = 1'b0;
        held_d = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", 32'(bus.valid_out), 32'd0);
        check_val("rst_data",  bus.data_out, 32'd0);
        check_val("rst_last",  32'(bus.last_out), 32'd0);

        // ramp frame: 11,13,...,99 one cycle after each bottom-right pixel
        n_out = 0; n_last = 0;
        frame(0, 0, 100);
        idle();
        check_val("ramp_count", n_out, 32'd25);
        check_val("ramp_lasts", n_last, 32'd1);
        check_val("ramp_final", bus.data_out, 32'd99);

        n_out = 0;
        frame(1, 0, 100);
        idle();
        check_val("neg_count", n_out, 32'd25);

        frame(2, 0, 100);
        frame(3, 0, 100);
        idle();

        // ramp again with ~40% idle gaps
        n_out = 0; n_last = 0;
        frame(0, 40, 100);
        repeat (3) idle();
        check_val("gap_count", n_out, 32'd25);
        check_val("gap_lasts", n_last, 32'd1);

        // two frames back to back
        n_out = 0; n_last = 0;
        frame(0, 0, 100);
        frame(0, 0, 100);
        idle();
        check_val("b2b_count", n_out, 32'd50);
        check_val("b2b_lasts", n_last, 32'd2);

        // abort after 37 pixels, then a clean frame
        frame(0, 0, 37);
        pulse_reset();
        idle();
        check_val("abort_data", bus.data_out, 32'd0);
        n_out = 0; n_last = 0;
        frame(0, 0, 100);
        repeat (2) idle();
        check_val("post_rst_count", n_out, 32'd25);
        check_val("post_rst_lasts", n_last, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
